// File: rtl/onoff_vc_buffer.sv
// Per-VC input buffer with on/off (credit-free) flow control toward upstream.
// Each VC is an independent circular FIFO with a hysteresis ON/OFF state machine.
module onoff_vc_buffer #(
  parameter int VC_NUM        = 2,
  parameter int BUFFER_DEPTH  = 8,
  parameter int FLIT_WIDTH    = 32,
  parameter int OFF_THRESHOLD = 6,
  parameter int ON_THRESHOLD  = 2,
  localparam int VC_W         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [VC_W-1:0]       vc_id_i,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  input  logic                  read_en_i,
  input  logic [VC_W-1:0]       read_vc_i,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic                  flit_valid_o,
  output logic [VC_NUM-1:0]     on_off_o,
  output logic [VC_NUM-1:0]     empty_o,
  output logic                  overflow_o
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] OFF_CNT  = CNT_W'(OFF_THRESHOLD);
  localparam logic [CNT_W-1:0] ON_CNT   = CNT_W'(ON_THRESHOLD);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);

  if (!(ON_THRESHOLD >= 0 && ON_THRESHOLD < OFF_THRESHOLD && OFF_THRESHOLD <= BUFFER_DEPTH))
  begin : g_paramCheck
    $error("onoff_vc_buffer: thresholds must satisfy 0 <= ON < OFF <= BUFFER_DEPTH");
  end

  typedef enum logic {
    ST_ON  = 1'b0,
    ST_OFF = 1'b1
  } fcState_t;

  logic [FLIT_WIDTH-1:0] r_mem       [VC_NUM][BUFFER_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr     [VC_NUM];
  logic [PTR_W-1:0]      r_rdPtr     [VC_NUM];
  logic [CNT_W-1:0]      r_cnt       [VC_NUM];
  logic [CNT_W-1:0]      w_cntNext   [VC_NUM];
  fcState_t              r_state     [VC_NUM];
  fcState_t              w_stateNext [VC_NUM];
  logic [VC_NUM-1:0]     w_wrEn;
  logic [VC_NUM-1:0]     w_rdEn;
  logic                  w_drop;
  logic                  r_overflow;

  // Fullness is judged on the current count, so a same-cycle pop never frees room for a write.
  always_comb begin
    w_wrEn = '0;
    w_rdEn = '0;
    w_drop = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_cntNext[v] = r_cnt[v];
      if (valid_i && (vc_id_i == VC_W'(v))) begin
        if (r_cnt[v] == FULL_CNT) begin
          w_drop = 1'b1;
        end else begin
          w_wrEn[v] = 1'b1;
        end
      end
      if (read_en_i && (read_vc_i == VC_W'(v)) && (r_cnt[v] != '0)) begin
        w_rdEn[v] = 1'b1;
      end
      if (w_wrEn[v] && !w_rdEn[v]) begin
        w_cntNext[v] = r_cnt[v] + CNT_W'(1);
      end else if (!w_wrEn[v] && w_rdEn[v]) begin
        w_cntNext[v] = r_cnt[v] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      w_stateNext[v] = r_state[v];
      case (r_state[v])
        ST_ON:   if (w_cntNext[v] >= OFF_CNT) w_stateNext[v] = ST_OFF;
        ST_OFF:  if (w_cntNext[v] <= ON_CNT)  w_stateNext[v] = ST_ON;
        default: w_stateNext[v] = ST_ON;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        r_wrPtr[v] <= '0;
        r_rdPtr[v] <= '0;
        r_cnt[v]   <= '0;
        r_state[v] <= ST_ON;
      end
      r_overflow <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_wrEn[v]) begin
          r_wrPtr[v] <= (r_wrPtr[v] == LAST_PTR) ? '0 : r_wrPtr[v] + PTR_W'(1);
        end
        if (w_rdEn[v]) begin
          r_rdPtr[v] <= (r_rdPtr[v] == LAST_PTR) ? '0 : r_rdPtr[v] + PTR_W'(1);
        end
        r_cnt[v]   <= w_cntNext[v];
        r_state[v] <= w_stateNext[v];
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; contents are only observable through a nonzero count.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_wrEn[v]) begin
        r_mem[v][r_wrPtr[v]] <= flit_i;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      on_off_o[v] = (r_state[v] == ST_ON);
      empty_o[v]  = (r_cnt[v] == '0);
    end
  end

  assign flit_o       = r_mem[read_vc_i][r_rdPtr[read_vc_i]];
  assign flit_valid_o = (r_cnt[read_vc_i] != '0);
  assign overflow_o   = r_overflow;

endmodule

// File: doc/onoff_vc_buffer.md
ONOFF_VC_BUFFER -- requirements
Module: onoff_vc_buffer

Interface
REQ-001 The module SHALL have parameter VC_NUM, default 2, meaning number of virtual channels on this input port.
REQ-002 The module SHALL have parameter BUFFER_DEPTH, default 8, meaning flit slots per VC.
REQ-003 The module SHALL have parameter FLIT_WIDTH, default 32, meaning flit width in bits.
REQ-004 The module SHALL have parameter OFF_THRESHOLD, default 6, meaning occupancy at or above which the VC signals off.
REQ-005 The module SHALL have parameter ON_THRESHOLD, default 2, meaning occupancy at or below which an off VC signals on again.
REQ-006 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 The module SHALL have port valid_i, input, 1, incoming flit valid.
REQ-009 The module SHALL have port vc_id_i, input, $clog2(VC_NUM), destination VC of the incoming flit.
REQ-010 The module SHALL have port flit_i, input, FLIT_WIDTH, incoming flit.
REQ-011 The module SHALL have port read_en_i, input, 1, switch-allocation grant: pop one flit.
REQ-012 The module SHALL have port read_vc_i, input, $clog2(VC_NUM), VC to pop or present.
REQ-013 The module SHALL have port flit_o, output, FLIT_WIDTH, head flit of VC read_vc_i.
REQ-014 The module SHALL have port flit_valid_o, output, 1, high when VC read_vc_i is non-empty.
REQ-015 The module SHALL have port on_off_o, output, VC_NUM, per-VC credit-free flow control to upstream; 1 = may send.
REQ-016 The module SHALL have port empty_o, output, VC_NUM, per-VC empty flag.
REQ-017 The module SHALL have port overflow_o, output, 1, sticky flag: a flit was dropped on a full VC.

Function
REQ-018 Parameters SHALL satisfy 0 <= ON_THRESHOLD < OFF_THRESHOLD <= BUFFER_DEPTH; violation SHALL be an elaboration error.
REQ-019 Each VC SHALL be an independent FIFO with read and write pointers that wrap from BUFFER_DEPTH-1 to 0, BUFFER_DEPTH not required to be a power of 2.
REQ-020 Each VC SHALL keep an occupancy counter of width $clog2(BUFFER_DEPTH+1), range 0..BUFFER_DEPTH.
REQ-021 A write with valid_i=1 to a non-full VC SHALL store flit_i at the write pointer and increment the counter at the same edge.
REQ-022 A write to a full VC SHALL be dropped, leaving contents, pointers and counter unchanged, and SHALL set overflow_o from the next cycle until reset.
REQ-023 flit_o and flit_valid_o SHALL be combinational from the head of VC read_vc_i; a written flit SHALL be visible in the cycle after its write edge (latency 1, no bypass).
REQ-024 A read with read_en_i=1 on a non-empty VC SHALL advance its read pointer and decrement its counter; a read on an empty VC SHALL be ignored, with no underflow.
REQ-025 A read and a write to the same VC in one cycle SHALL both take effect, counter unchanged; on a full VC the write SHALL still be dropped (no cut-through into the freed slot).
REQ-026 Each VC SHALL hold a two-state flow-control FSM, ON and OFF, registered, with on_off_o[vc]=1 in ON.
REQ-027 ON->OFF SHALL occur at the edge where the next-state counter is >= OFF_THRESHOLD.
REQ-028 OFF->ON SHALL occur at the edge where the next-state counter is <= ON_THRESHOLD.
REQ-029 Otherwise the FSM SHALL hold (hysteresis), so on_off_o[vc] changes in the same cycle as the counter update becomes visible.
REQ-030 empty_o[vc] SHALL equal (counter == 0), registered-state derived.

Reset
REQ-031 rst low SHALL asynchronously clear:
- all counters and pointers to 0
- overflow_o to 0
- every FSM to ON (on_off_o all 1)
- empty_o all 1, flit_valid_o 0
REQ-032 FIFO storage SHALL NOT require reset; flit_o is don't-care while flit_valid_o=0.
REQ-033 Release of rst SHALL be synchronised by the integrator; the first write is accepted at the first rising edge with rst high.

Verification (defaults: VC_NUM=2, DEPTH=8, OFF=6, ON=2)
REQ-034 Reset check: assert rst low mid-stream with VC0 holding 5 flits -> immediately on_off_o=2'b11, empty_o=2'b11, overflow_o=0, flit_valid_o=0.
REQ-035 Off trip: 6 consecutive writes to VC0 -> on_off_o[0] falls in the cycle after the 6th edge, not after the 5th; on_off_o[1] stays 1.
REQ-036 Hysteresis: from occupancy 6, pop VC0 four times -> on_off_o[0] stays 0 at occupancies 5 and 3, and returns to 1 only at occupancy 2.
REQ-037 Overflow: 9 writes with data 1..9 to VC1, no reads -> flit 9 dropped, overflow_o=1 sticky; 8 pops return 1..8 in order, then empty_o[1]=1.
REQ-038 Simultaneous events, part 1: VC0 at occupancy 6 gets a write and a read in one cycle -> occupancy stays 6, on_off_o[0] stays 0, FIFO order preserved.
REQ-039 Simultaneous events, part 2: read_en_i on empty VC1 -> no state change, flit_valid_o=0.
